// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
// The CHECK state only exists when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_STRIDE    = 4;
    localparam int CHECKSUM_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK   = 3'd3,
`endif
        ST_DONE    = 3'd4
    } state_e;

    // Running XOR checksum over accepted stream bytes.
    function automatic logic [CHECKSUM_WIDTH-1:0] xor_fold(
        input logic [CHECKSUM_WIDTH-1:0] acc,
        input logic [7:0]                data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Command, byte-stream and memory-write signals of imem_loader.
// slave = the loader itself, master = whoever commands it and feeds bytes.
interface imem_loader_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int COUNT_WIDTH = 7
);
    logic                   start;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [COUNT_WIDTH-1:0] word_count;
    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   byte_ready;
    logic                   mem_write_enable;
    logic [ADDR_WIDTH-1:0]  mem_address;
    logic [31:0]            mem_write_data;
    logic                   pc_hold;
    logic                   busy;
    logic                   done;
    logic                   error;

    modport master (
        output start, base_addr, word_count, byte_valid, byte_data,
        input  byte_ready, mem_write_enable, mem_address, mem_write_data,
               pc_hold, busy, done, error
    );

    modport slave (
        input  start, base_addr, word_count, byte_valid, byte_data,
        output byte_ready, mem_write_enable, mem_address, mem_write_data,
               pc_hold, busy, done, error
    );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs four stream bytes MSB-first into one 32-bit instruction word.
// word_complete flags the shift that delivers the fourth byte.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);
    logic [31:0] shift_r;
    logic [1:0]  cnt_r;

    assign word          = shift_r;
    assign word_complete = shift_en & (cnt_r == 2'(BYTES_PER_WORD - 1));

    // Shift register and byte counter; the counter wraps to 0 after each word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= 32'd0;
            cnt_r   <= 2'd0;
        end else if (clr) begin
            shift_r <= 32'd0;
            cnt_r   <= 2'd0;
        end else if (shift_en) begin
            shift_r <= {shift_r[23:0], byte_in};
            cnt_r   <= cnt_r + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Runtime program download into instruction_memory; holds fetch (pc_hold) while loading.
// Define IMEM_LOADER_CHECKSUM_EN to require an XOR trailer byte after the last word.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int COUNT_WIDTH = 7
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK      = ~ADDR_WIDTH'(WORD_STRIDE - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD_ADDR = ADDR_WIDTH'((2 ** ADDR_WIDTH) - WORD_STRIDE);

    state_e                 state_r, state_next_s;
    logic [ADDR_WIDTH-1:0]  addr_r, addr_next_s;
    logic [COUNT_WIDTH-1:0] remaining_r, remaining_next_s;
    logic                   error_r, error_next_s;
    logic                   busy_r, byte_ready_r, mem_we_r, done_r;
    logic                   clr_s, handshake_s, shift_en_s, word_complete_s;
    logic [31:0]            word_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CHECKSUM_WIDTH-1:0] csum_r, csum_next_s;
`endif

    assign handshake_s = bus.byte_valid & byte_ready_r;
    assign shift_en_s  = handshake_s & (state_r == ST_COLLECT);

    byte_assembler u_assembler (
        .clk           (clk),
        .rst_n         (reset),
        .clr           (clr_s),
        .shift_en      (shift_en_s),
        .byte_in       (bus.byte_data),
        .word          (word_s),
        .word_complete (word_complete_s)
    );

    // Next-state, address/count bookkeeping and checksum update.
    always_comb begin
        state_next_s     = state_r;
        addr_next_s      = addr_r;
        remaining_next_s = remaining_r;
        error_next_s     = error_r;
        clr_s            = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_next_s      = csum_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    clr_s            = 1'b1;
                    addr_next_s      = bus.base_addr & ADDR_MASK;
                    remaining_next_s = bus.word_count;
                    error_next_s     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next_s      = CHECKSUM_WIDTH'(0);
`endif
                    if (bus.word_count == COUNT_WIDTH'(0)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_COLLECT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (handshake_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next_s = xor_fold(csum_r, bus.byte_data);
`endif
                    if (word_complete_s) begin
                        state_next_s = ST_WRITE;
                    end else begin
                        state_next_s = ST_COLLECT;
                    end
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                remaining_next_s = remaining_r - COUNT_WIDTH'(1);
                addr_next_s      = addr_r + ADDR_WIDTH'(WORD_STRIDE);
                if (remaining_r == COUNT_WIDTH'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next_s = ST_CHECK;
`else
                    state_next_s = ST_DONE;
`endif
                end else if (addr_r == LAST_WORD_ADDR) begin
                    // More words requested than fit below the top of memory.
                    error_next_s = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (handshake_s) begin
                    if (bus.byte_data != csum_r) begin
                        error_next_s = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
`endif
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; outputs are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= '0;
            remaining_r  <= '0;
            error_r      <= 1'b0;
            busy_r       <= 1'b0;
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            done_r       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r       <= CHECKSUM_WIDTH'(0);
`endif
        end else begin
            state_r      <= state_next_s;
            addr_r       <= addr_next_s;
            remaining_r  <= remaining_next_s;
            error_r      <= error_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            mem_we_r     <= (state_next_s == ST_WRITE);
            done_r       <= (state_next_s == ST_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r       <= csum_next_s;
            byte_ready_r <= (state_next_s == ST_COLLECT) || (state_next_s == ST_CHECK);
`else
            byte_ready_r <= (state_next_s == ST_COLLECT);
`endif
        end
    end

    assign bus.byte_ready       = byte_ready_r;
    assign bus.mem_write_enable = mem_we_r;
    assign bus.mem_address      = addr_r;
    assign bus.mem_write_data   = word_s;
    assign bus.pc_hold          = busy_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
    assign bus.error            = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads plus randomized loads checked
// against a list-of-writes model derived from base, count and the byte stream.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset;

    imem_loader_if #(.ADDR_WIDTH(8), .COUNT_WIDTH(7)) bus ();

    imem_loader #(.ADDR_WIDTH(8), .COUNT_WIDTH(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          hold_bad = 0;
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  stim_q[$];
    bit          trailer_forced = 1'b0;
    logic [7:0]  trailer_val = 8'h00;

    // Observe writes, done pulses and the pc_hold/busy relationship mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_write_enable) begin
                wa_q.push_back(bus.mem_address);
                wd_q.push_back(bus.mem_write_data);
            end
            if (bus.done) begin
                done_cnt++;
                if (!bus.pc_hold) hold_bad++;
            end
            if (bus.pc_hold !== bus.busy) hold_bad++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        guard = 0;
        while (!bus.byte_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("byte_accept", guard < 40, 1'b1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
    endtask

    // gap < 0 selects a random 0..3 cycle stall before each byte.
    task automatic run_load(input logic [7:0] base, input logic [6:0] count,
                            input int gap, input bit poke);
        int         room, n_exp, guard;
        bit         ovf, exp_err;
        logic [7:0] ab, x;
        ab    = base & 8'hFC;
        room  = (256 - int'(ab)) / 4;
        n_exp = (int'(count) < room) ? int'(count) : room;
        ovf   = int'(count) > room;
        x     = 8'h00;
        exp_err = ovf;
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        hold_bad = 0;

        @(negedge clk);
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = count;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.base_addr  = 8'($urandom);
        bus.word_count = 7'($urandom);
        check("busy_latency", bus.busy, 1'b1);
        check("error_cleared", bus.error, 1'b0);

        for (int i = 0; i < n_exp * 4; i++) begin
            send_byte(stim_q[i], (gap < 0) ? int'($urandom_range(3, 0)) : gap);
            x = x ^ stim_q[i];
            if (poke && i == 1) begin
                bus.start      = 1'b1;
                bus.base_addr  = 8'h80;
                bus.word_count = 7'd5;
                @(negedge clk);
                bus.start      = 1'b0;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (count != 7'd0 && !ovf) begin
            send_byte(trailer_forced ? trailer_val : x, 0);
            exp_err = trailer_forced && (trailer_val != x);
        end
`endif

        guard = 0;
        while (bus.busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("busy_drop", bus.busy, 1'b0);
        repeat (3) @(negedge clk);

        check("n_writes", wa_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < wa_q.size(); i++) begin
            check("wr_addr", wa_q[i], ab + 8'(4 * i));
            check("wr_data", wd_q[i], {stim_q[4*i], stim_q[4*i+1], stim_q[4*i+2], stim_q[4*i+3]});
        end
        check("done_pulses", done_cnt, exp_err ? 0 : 1);
        check("error_flag", bus.error, exp_err);
        check("pc_hold_tracks_busy", hold_bad, 0);
        check("idle_ready", bus.byte_ready, 1'b0);
    endtask

    initial begin
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = 8'h00;
        bus.word_count = 7'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.byte_ready, bus.mem_write_enable, bus.mem_address,
              bus.mem_write_data, bus.pc_hold, bus.busy, bus.done, bus.error}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {bus.busy, bus.byte_ready}, 2'b00);

        // Reset in the middle of a word discards it.
        wa_q.delete();
        bus.start      = 1'b1;
        bus.base_addr  = 8'h10;
        bus.word_count = 7'd1;
        @(negedge clk);
        bus.start = 1'b0;
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 reset = 1'b0;
        #1;
        check("async_reset_outputs", {bus.byte_ready, bus.mem_write_enable, bus.mem_address,
              bus.mem_write_data, bus.pc_hold, bus.busy, bus.done, bus.error}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_idle", {bus.busy, bus.pc_hold, bus.byte_ready}, 3'b000);
        check("post_reset_no_write", wa_q.size(), 0);
        stim_q = '{8'hE2, 8'h11, 8'h00, 8'h00};
        run_load(8'h00, 7'd1, 0, 1'b0);

        // Three-word program, with a start pulse ignored mid-load.
        stim_q = '{8'hE2, 8'h11, 8'h00, 8'h00, 8'hE0, 8'h80, 8'h51, 8'h83,
                   8'h1A, 8'hFF, 8'hFF, 8'hFD};
        run_load(8'h00, 7'd3, 0, 1'b1);
        run_load(8'h00, 7'd3, 3, 1'b0);

        // Address overflow near the top of memory, then an empty load.
        run_load(8'hF8, 7'd3, 0, 1'b0);
        run_load(8'h40, 7'd0, 0, 1'b0);
        run_load(8'hFE, 7'd1, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        trailer_forced = 1'b1;
        trailer_val    = 8'h44;
        run_load(8'h20, 7'd1, 0, 1'b0);
        trailer_val    = 8'h00;
        run_load(8'h20, 7'd1, 0, 1'b0);
        trailer_forced = 1'b0;
`endif

        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic [6:0] c;
            b = 8'($urandom);
            if ($urandom_range(2, 0) == 0) b = 8'hE0 | 8'($urandom_range(31, 0));
            c = 7'($urandom_range(6, 0));
            stim_q.delete();
            for (int k = 0; k < 4 * int'(c); k++) stim_q.push_back(8'($urandom));
            trailer_forced = ($urandom_range(3, 0) == 0);
            trailer_val    = 8'($urandom);
            run_load(b, c, -1, ($urandom_range(1, 0) == 1));
        end
        trailer_forced = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
